apb_req_arbiter: RTL
====================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL provide parameter ADDRWIDTH, default 16, which sets the APB address width.
REQ-002 The block SHALL provide parameter TIMEOUT, default 255, which sets the maximum number of wait cycles in ACCESS; 0 disables the timeout.
REQ-003 The block SHALL provide port PCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL provide port PRESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL provide, for each n in {0,1}, the following requester ports:
- reqN, input, 1 bit: transfer request;
- addrN, input, ADDRWIDTH bits;
- writeN, input, 1 bit;
- wdataN, input, 32 bits;
- rdataN, output, 32 bits;
- doneN, output, 1 bit: one-cycle completion pulse;
- errN, output, 1 bit: completion status, valid while doneN is high.
REQ-006 The block SHALL provide APB master outputs PSEL (1), PENABLE (1), PADDR (ADDRWIDTH), PWRITE (1), PWDATA (32), PSTRB (4) and PPROT (3).
REQ-007 The block SHALL provide APB master inputs PRDATA (32), PREADY (1) and PSLVERR (1).
REQ-008 The block SHALL provide status outputs busy (1 bit, high whenever state is not IDLE) and grant (2 bits, one-hot, the current owner; 0 in IDLE).

Function
REQ-009 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS, DONE.
REQ-010 IDLE: if any reqN is high, the FSM SHALL select an owner and move to SETUP; otherwise it stays in IDLE.
REQ-011 Arbitration SHALL be round-robin. With a single request, that requester wins. With both requests, the requester that was not granted last wins.
REQ-012 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-013 On the IDLE->SETUP edge, the block SHALL register PADDR=addr, PWRITE=write and PWDATA=wdata of the winner.
REQ-014 On the same edge, PSTRB SHALL be set to 4'hF for writes and 4'h0 for reads.
REQ-015 PADDR, PWRITE and PWDATA SHALL then hold stable until the next SETUP.
REQ-016 PPROT SHALL be tied to 3'b000.
REQ-017 SETUP SHALL last exactly one cycle with PSEL=1 and PENABLE=0, then move to ACCESS.
REQ-018 ACCESS SHALL drive PSEL=1 and PENABLE=1 and remain until PREADY=1 or the timeout fires.
REQ-019 On PREADY=1 in ACCESS, the block SHALL move to DONE. It SHALL register rdataN=PRDATA for reads (rdataN holds its previous value on writes) and errN=PSLVERR.
REQ-020 A wait counter SHALL increment on each ACCESS cycle with PREADY=0 and clear on entry to SETUP.
REQ-021 If TIMEOUT>0 and the counter reaches TIMEOUT with PREADY still 0, the block SHALL move to DONE with errN=1 and rdataN=32'h0.
REQ-022 If PREADY=1 in the same cycle the counter reaches TIMEOUT, the block SHALL treat it as a normal completion, not a timeout.
REQ-023 DONE SHALL last exactly one cycle: doneN=1 for the owner only, PSEL=0, PENABLE=0. The next state SHALL be IDLE.
REQ-024 A requester SHALL hold reqN high with stable addrN/writeN/wdataN until doneN, and drop reqN in the doneN cycle or the following one.
REQ-025 A reqN still high in IDLE SHALL be treated as a new request.
REQ-026 Minimum latency SHALL be as follows. If reqN is sampled high in IDLE at edge k, then SETUP occupies cycle k+1, ACCESS occupies k+2, and with zero-wait PREADY doneN is high in cycle k+3. Back-to-back transfers therefore occupy 4 cycles each.
REQ-027 A reqN drop while that requester owns the bus SHALL NOT abort the transfer; the transfer completes and doneN still pulses.
REQ-028 A request arriving during SETUP, ACCESS or DONE SHALL wait and be arbitrated in the next IDLE.
REQ-029 errN SHALL be 0 whenever doneN is 0.
REQ-030 rdataN SHALL hold its last value between completions.

Reset
REQ-031 PRESET=1 SHALL asynchronously force the following, at any time including mid-transfer:
- state=IDLE;
- PSEL, PENABLE and PWRITE = 0;
- PADDR, PWDATA and PSTRB = 0;
- rdata0/1 = 0; done0/1 = 0; err0/1 = 0;
- busy = 0; grant = 0;
- wait counter = 0; last-grant = 1.
REQ-032 After PRESET falls, the first rising edge SHALL evaluate IDLE normally.
REQ-033 A transfer interrupted by reset SHALL NOT produce doneN.

Verification
REQ-034 Single read: req0=1, addr0=16'h2004, PREADY=1, PRDATA=32'hA5A5_0001. Required: PSEL/PENABLE sequence 10 then 11; done0 pulses in cycle k+3 with rdata0=32'hA5A5_0001 and err0=0.
REQ-035 Tie and round-robin: req0 and req1 both held high for 3 transfers. Required grant order 0,1,0, with every transfer 4 cycles apart.
REQ-036 Wait states and error: req1 write with wdata1=32'h0000_00FF; PREADY low for 3 ACCESS cycles, then PREADY=1 with PSLVERR=1. Required: PSTRB=4'hF, ACCESS lasts 4 cycles, done1=1 with err1=1.
REQ-037 Timeout: TIMEOUT=4, PREADY held 0. Required: done0=1 with err0=1 and rdata0=0 after 4 wait cycles; PSEL=0 in the DONE cycle.
REQ-038 Timeout boundary: PREADY=1 in the same cycle the counter reaches TIMEOUT. Required: err0=PSLVERR (0) and rdata0=PRDATA.
REQ-039 Reset in ACCESS: PRESET pulsed high in ACCESS. Required: PSEL, PENABLE and busy go to 0 immediately, no done pulse, and requester 0 wins the next tie.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin arbitration in front of one APB bus.
// Each requester gets a one-cycle done pulse carrying the error status, and its
// own read-data register that holds between completions.
module apb_req_arbiter #(
  parameter int unsigned ADDRWIDTH = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  // requester 0
  input  logic                 req0,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic                 write0,
  input  logic [31:0]          wdata0,
  output logic [31:0]          rdata0,
  output logic                 done0,
  output logic                 err0,
  // requester 1
  input  logic                 req1,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic                 write1,
  input  logic [31:0]          wdata1,
  output logic [31:0]          rdata1,
  output logic                 done1,
  output logic                 err1,
  // APB master
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR,
  // status
  output logic                 busy,
  output logic [1:0]           grant
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Value of the wait counter in the ACCESS cycle that would be the TIMEOUT-th wait.
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;   // current owner, doubles as last grant
  logic [CntW-1:0]        wait_q, wait_d;
  logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [31:0]            pwdata_q, pwdata_d;
  logic [3:0]             pstrb_q, pstrb_d;
  logic [1:0][31:0]       rdata_q, rdata_d;
  logic [1:0]             err_q, err_d;

  logic winner;
  logic timeout_hit;

  // Tie goes to whoever was not granted last; a lone request simply wins.
  assign winner      = (req0 && req1) ? ~owner_q : req1;
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == TimeoutLast);

  // Next-state, arbitration and completion capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wait_d   = wait_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d  = StSetup;
          owner_d  = winner;
          wait_d   = '0;
          paddr_d  = winner ? addr1  : addr0;
          pwrite_d = winner ? write1 : write0;
          pwdata_d = winner ? wdata1 : wdata0;
          pstrb_d  = (winner ? write1 : write0) ? 4'hF : 4'h0;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // PREADY wins over a timeout landing in the same cycle.
        if (PREADY) begin
          state_d = StDone;
          if (!pwrite_q) rdata_d[owner_q] = PRDATA;
          err_d[owner_q] = PSLVERR;
        end else if (timeout_hit) begin
          state_d          = StDone;
          rdata_d[owner_q] = '0;
          err_d[owner_q]   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= StIdle;
      owner_q  <= 1'b1;
      wait_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wait_q   <= wait_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from state; err is only visible alongside done.
  always_comb begin
    PSEL    = (state_q == StSetup) || (state_q == StAccess);
    PENABLE = (state_q == StAccess);
    busy    = (state_q != StIdle);
    grant   = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    done0   = (state_q == StDone) && !owner_q;
    done1   = (state_q == StDone) && owner_q;
    err0    = done0 && err_q[0];
    err1    = done1 && err_q[1];
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;
  assign PSTRB  = pstrb_q;
  assign PPROT  = 3'b000;
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

endmodule
